// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate divider, raster counters, blanking/frame strobes
// and a one-pixel output register stage that keeps colour and syncs aligned at the pins.
module vga_sync_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int CLK_DIV   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] rgb_in,
    output logic        pix_tick,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        video_on,
    output logic        frame_tick,
    output logic [11:0] vga_rgb,
    output logic        vga_hs,
    output logic        vga_vs
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] X_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] Y_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             video_on_q, video_on_d;
    logic             frame_tick_q, frame_tick_d;
    logic [11:0]      rgb_q, rgb_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             tick;

    // Gated by rst so a divide-by-one build still reads 0 while held in reset.
    assign tick = (div_q == DIV_MAX) && !rst;

    always_comb begin
        div_d        = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;
        x_d          = x_q;
        y_d          = y_q;
        rgb_d        = rgb_q;
        hs_d         = hs_q;
        vs_d         = vs_q;
        if (tick) begin
            if (x_q == X_MAX) begin
                x_d = '0;
                y_d = (y_q == Y_MAX) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
            // Pin stage is loaded from the pixel being left, giving one pixel of latency.
            rgb_d = video_on_q ? rgb_in : 12'h000;
            hs_d  = !((x_q >= HS_START) && (x_q < HS_END));
            vs_d  = !((y_q >= VS_START) && (y_q < VS_END));
        end
        video_on_d   = (x_d < X_VIS) && (y_d < Y_VIS);
        frame_tick_d = tick && (x_d == 10'd0) && (y_d == Y_VIS);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q        <= '0;
            x_q          <= '0;
            y_q          <= '0;
            video_on_q   <= 1'b1;
            frame_tick_q <= 1'b0;
            rgb_q        <= 12'h000;
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
        end else begin
            div_q        <= div_d;
            x_q          <= x_d;
            y_q          <= y_d;
            video_on_q   <= video_on_d;
            frame_tick_q <= frame_tick_d;
            rgb_q        <= rgb_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
        end
    end

    assign pix_tick   = tick;
    assign pixel_x    = x_q;
    assign pixel_y    = y_q;
    assign video_on   = video_on_q;
    assign frame_tick = frame_tick_q;
    assign vga_rgb    = rgb_q;
    assign vga_hs     = hs_q;
    assign vga_vs     = vs_q;

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 The module SHALL have parameter H_DISPLAY, default 640, visible pixels per line.
REQ-002 The module SHALL have parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 The module SHALL have parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 The module SHALL have parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-005 The module SHALL have parameter V_DISPLAY, default 480, visible lines per frame.
REQ-006 The module SHALL have parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 The module SHALL have parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 The module SHALL have parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 The module SHALL have parameter CLK_DIV, default 2, system clocks per pixel, minimum 1.
REQ-010 The module SHALL have one clock and an asynchronous, active-high reset: clk input 1 system clock; rst input 1 asynchronous active-high reset.
REQ-011 pix_tick output 1: one-clk pulse per pixel period.
REQ-012 pixel_x output 10: current horizontal count, 0..H_TOTAL-1.
REQ-013 pixel_y output 10: current vertical count, 0..V_TOTAL-1.
REQ-014 video_on output 1: high when pixel_x < H_DISPLAY and pixel_y < V_DISPLAY.
REQ-015 frame_tick output 1: one-clk pulse at the start of vertical blanking.
REQ-016 rgb_in input 12: 4:4:4 colour for the current (pixel_x, pixel_y).
REQ-017 vga_rgb output 12, vga_hs output 1, vga_vs output 1: pin-level colour and active-low syncs, mutually aligned.

Function
REQ-018 H_TOTAL SHALL equal H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800) and V_TOTAL SHALL equal V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
REQ-019 A divider counter SHALL count 0..CLK_DIV-1 on every clk, and pix_tick SHALL be high exactly on clocks where it equals CLK_DIV-1; with CLK_DIV=1, pix_tick SHALL be constantly high after reset.
REQ-020 pixel_x and pixel_y SHALL be registers that change only on clocks where pix_tick is high.
REQ-021 On pix_tick, pixel_x SHALL increment, wrapping H_TOTAL-1 -> 0.
REQ-022 pixel_y SHALL increment only on that wrap, wrapping V_TOTAL-1 -> 0; at (799,524) both wrap to (0,0) on the same tick.
REQ-023 video_on SHALL be a registered output consistent with the current pixel_x/pixel_y on every clock, with no combinational glitch.
REQ-024 frame_tick SHALL pulse high for exactly one clk, on the clock following the pix_tick that moves the counters to (0, V_DISPLAY), i.e. once per frame.
REQ-025 Game logic SHALL use frame_tick to start its per-frame update, so updates run in vertical blank.
REQ-026 On each pix_tick, vga_rgb SHALL be loaded with rgb_in if video_on is high, otherwise with 0.
REQ-027 On that same pix_tick, vga_hs SHALL be loaded low iff H_DISPLAY+H_FRONT <= pixel_x < H_DISPLAY+H_FRONT+H_SYNC (656..751).
REQ-028 On that same pix_tick, vga_vs SHALL be loaded low iff V_DISPLAY+V_FRONT <= pixel_y < V_DISPLAY+V_FRONT+V_SYNC (490..491).
REQ-029 The result of REQ-026..028 SHALL be a fixed one-pixel pipeline latency from counters to pins.
REQ-030 Coordinates outside the visible area, including the off-screen object position (720,500), SHALL never produce nonzero vga_rgb.

Reset
REQ-031 While rst is high, the divider, pixel_x and pixel_y SHALL be 0.
REQ-032 While rst is high, pix_tick, frame_tick and vga_rgb SHALL be 0, video_on SHALL be 1, and vga_hs and vga_vs SHALL be 1.
REQ-033 Reset assertion mid-line or mid-frame SHALL take effect immediately, without waiting for clk.
REQ-034 After reset release, the first pix_tick SHALL occur on the CLK_DIV-th rising clk edge.
REQ-035 After reset release, the timing SHALL restart at (0,0) with no partial-frame frame_tick.

Verification
REQ-036 Release reset with CLK_DIV=2 -> pix_tick on every 2nd clk; pixel_x reaches 799 then 0 after 1600 clks, and pixel_y becomes 1.
REQ-037 Run two full frames -> frame_tick pulses exactly twice, 840000 clks apart; at each pulse (pixel_x,pixel_y)=(0,480).
REQ-038 Monitor one line -> vga_hs low for exactly 96 pix_ticks, falling one pixel after pixel_x=656.
REQ-039 Monitor one frame -> vga_vs low for exactly 2 lines (1600 pixels), starting one pixel after pixel_y becomes 490.
REQ-040 Hold rgb_in=12'hFFF constantly -> vga_rgb is 12'hFFF for exactly 640x480 pix_ticks per frame and 0 elsewhere, including at (720,500)-equivalent blank positions.
REQ-041 Assert rst at pixel (300,200), then release -> all outputs take reset values asynchronously, counting resumes at (0,0), and no frame_tick occurs until (0,480) is reached.
